pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port fetch_pc_enable  in  1  1 = PC may advance; 0 = hold.
REQ-004 SHALL have port pc_sel  in  2  redirect code: 00 sequential, 01 reboot, 10 interrupt vector, 11 branch/call target.
REQ-005 SHALL have port branch_target  in  32  target for pc_sel=11.
REQ-006 SHALL have port pop_pc2  in  1  stack pop of high PC half; dmem_rdata valid this cycle.
REQ-007 SHALL have port pop_pc1  in  1  stack pop of low PC half; completes return.
REQ-008 SHALL have port dmem_rdata  in  16  data-memory read word.
REQ-009 SHALL have port imem_data  in  16  instruction-memory word, combinational read of imem_addr.
REQ-010 SHALL have port imem_addr  out  32  instruction-memory address.
REQ-011 SHALL have port pc  out  32  current PC register.
REQ-012 SHALL have port fetch_flush  out  1  1-cycle pulse after any non-sequential PC load.
REQ-013 SHALL have port vec_busy  out  1  high while in a vector-load state.

Function
REQ-014 SHALL implement states BOOT_HI, BOOT_LO, RUN, INT_HI, INT_LO.
REQ-015 imem_addr SHALL be 0 in BOOT_HI, 1 in BOOT_LO, 2 in INT_HI, 3 in INT_LO, and pc in RUN.
REQ-016 In BOOT_HI/INT_HI, imem_data SHALL be latched into vector staging [31:16], then go to BOOT_LO/INT_LO.
REQ-017 In BOOT_LO/INT_LO, pc SHALL load {staging, imem_data}, fetch_flush SHALL pulse the next cycle, and the state SHALL go to RUN.
REQ-018 vec_busy SHALL be 1 in all states except RUN.
REQ-019 All inputs other than rst SHALL be ignored in vector states.
REQ-020 RUN priority per cycle SHALL be: pop_pc1 > pc_sel=11 > pc_sel=10 > pc_sel=01 > fetch_pc_enable > hold.
REQ-021 pop_pc2 SHALL latch dmem_rdata into return staging [31:16] without changing pc.
REQ-022 pop_pc1 SHALL load pc = {return staging, dmem_rdata} and flush.
REQ-023 When pop_pc1 and pop_pc2 are both asserted, pop_pc1 SHALL win and return staging SHALL be unchanged.
REQ-024 pc_sel=11 SHALL load pc = branch_target and flush.
REQ-025 pc_sel=10 SHALL go to INT_HI with pc held; flush at INT_LO completion only.
REQ-026 pc_sel=01 SHALL go to BOOT_HI with pc held.
REQ-027 Redirects (pop_pc1, pc_sel≠00) SHALL apply regardless of fetch_pc_enable.
REQ-028 With fetch_pc_enable=1 and no redirect, pc SHALL become pc+1 modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
REQ-029 pop_pc1 with no preceding pop_pc2 SHALL use the current return staging contents; no error is raised.
REQ-030 fetch_flush SHALL be registered: exactly one cycle, the cycle after the load.

Reset
REQ-031 While rst=0: state=BOOT_HI, pc=0, both staging registers=0, fetch_flush=0, vec_busy=1, imem_addr=0.
REQ-032 Reset assertion mid-vector-load or mid-pop pair SHALL abort it; after release the boot sequence SHALL restart from BOOT_HI.

Structure
REQ-033 State encoding, vector addresses (0..3) and pc_sel codes SHALL live in the shared processor package.
REQ-034 The block SHALL be a single module with no sub-modules; both staging registers SHALL be local.

Verification
REQ-035 Boot: imem[0]=0x0000, imem[1]=0x0040, release rst -> pc=0x00000040 on the 2nd edge, fetch_flush one cycle later, vec_busy low.
REQ-036 Sequential/wrap: pc=0xFFFFFFFE, fetch_pc_enable=1 for 2 cycles -> 0xFFFFFFFF then 0x00000000; enable=0 -> pc holds.
REQ-037 Return: pop_pc2 with dmem_rdata=0x1234, then pop_pc1 with 0x5678 -> pc=0x12345678, one flush pulse.
REQ-038 Interrupt: imem[2]=0x0000, imem[3]=0x0200, pc_sel=10 at pc=0x50 -> pc holds 0x50 for 2 cycles, then 0x00000200.
REQ-039 Priority: pop_pc1 (rdata 0x0010, staging 0) with pc_sel=11 (target 0x99) in the same cycle -> pc=0x00000010.
REQ-040 Mid-operation reset: rst=0 in INT_LO -> pc=0 immediately; after release, the boot sequence re-runs from address 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared processor definitions for the program-counter unit: FSM states,
// reset/interrupt vector word addresses and pc_sel redirect codes.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_HI = 3'd0,
    ST_BOOT_LO = 3'd1,
    ST_RUN     = 3'd2,
    ST_INT_HI  = 3'd3,
    ST_INT_LO  = 3'd4
  } pc_state_e;

  // Each vector is two 16-bit instruction-memory words, high half first.
  localparam logic [31:0] VEC_BOOT_HI_ADDR = 32'd0;
  localparam logic [31:0] VEC_BOOT_LO_ADDR = 32'd1;
  localparam logic [31:0] VEC_INT_HI_ADDR  = 32'd2;
  localparam logic [31:0] VEC_INT_LO_ADDR  = 32'd3;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_REBOOT = 2'b01;
  localparam logic [1:0] PC_SEL_INT    = 2'b10;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

  function automatic logic is_vec_state(pc_state_e s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with boot/interrupt vector fetch, branch and two-part stack return.
// Loads take effect on the next edge; fetch_flush follows one cycle later; no backpressure.
module pc_unit
  import pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_pc_enable,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic        pop_pc2,
  input  logic        pop_pc1,
  input  logic [15:0] dmem_rdata,
  input  logic [15:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        fetch_flush,
  output logic        vec_busy
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] vec_stage_q, vec_stage_d;
  logic [15:0] ret_stage_q, ret_stage_d;
  logic        flush_q, flush_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT_HI;
      pc_q        <= 32'd0;
      vec_stage_q <= 16'd0;
      ret_stage_q <= 16'd0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      vec_stage_q <= vec_stage_d;
      ret_stage_q <= ret_stage_d;
      flush_q     <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vec_stage_d = vec_stage_q;
    ret_stage_d = ret_stage_q;
    flush_d     = 1'b0;
    unique case (state_q)
      ST_BOOT_HI: begin
        vec_stage_d = imem_data;
        state_d     = ST_BOOT_LO;
      end
      ST_INT_HI: begin
        vec_stage_d = imem_data;
        state_d     = ST_INT_LO;
      end
      ST_BOOT_LO, ST_INT_LO: begin
        pc_d    = {vec_stage_q, imem_data};
        flush_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop_pc1) begin
          pc_d    = {ret_stage_q, dmem_rdata};
          flush_d = 1'b1;
        end else if (pc_sel == PC_SEL_BRANCH) begin
          pc_d    = branch_target;
          flush_d = 1'b1;
        end else if (pc_sel == PC_SEL_INT) begin
          state_d = ST_INT_HI;
        end else if (pc_sel == PC_SEL_REBOOT) begin
          state_d = ST_BOOT_HI;
        end else if (fetch_pc_enable) begin
          pc_d = pc_q + 32'd1;
        end
        // A simultaneous pop_pc1 consumes the old high half, so the new one is dropped.
        if (pop_pc2 && !pop_pc1) begin
          ret_stage_d = dmem_rdata;
        end
      end
      default: begin
        state_d = ST_BOOT_HI;
      end
    endcase
  end

  always_comb begin
    imem_addr = pc_q;
    unique case (state_q)
      ST_BOOT_HI: imem_addr = VEC_BOOT_HI_ADDR;
      ST_BOOT_LO: imem_addr = VEC_BOOT_LO_ADDR;
      ST_INT_HI:  imem_addr = VEC_INT_HI_ADDR;
      ST_INT_LO:  imem_addr = VEC_INT_LO_ADDR;
      default:    imem_addr = pc_q;
    endcase
  end

  assign pc          = pc_q;
  assign fetch_flush = flush_q;
  assign vec_busy    = is_vec_state(state_q);

endmodule

// File: tb/tb_pc_unit.sv
// Directed table, hand sequences and randomized run of pc_unit against a behavioural model.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        fetch_pc_enable;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic        pop_pc2;
  logic        pop_pc1;
  logic [15:0] dmem_rdata;
  logic [15:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        fetch_flush;
  logic        vec_busy;

  logic [15:0] imem [0:3];

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc_enable (fetch_pc_enable),
    .pc_sel          (pc_sel),
    .branch_target   (branch_target),
    .pop_pc2         (pop_pc2),
    .pop_pc1         (pop_pc1),
    .dmem_rdata      (dmem_rdata),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .pc              (pc),
    .fetch_flush     (fetch_flush),
    .vec_busy        (vec_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: four vector words, anything else returns a filler pattern.
  always_comb begin
    if (imem_addr < 32'd4) imem_data = imem[imem_addr[1:0]];
    else                   imem_data = 16'hA5A5 ^ imem_addr[15:0];
  end

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc;
  logic [15:0] m_ret_hi;
  logic [15:0] m_vec_hi;
  logic        m_flush;
  int          m_left;   // vector words still to fetch (0 = running)
  int          m_base;   // first word address of the vector being fetched

  function automatic logic [31:0] m_addr();
    if (m_left == 0) return m_pc;
    return 32'(m_base + 2 - m_left);
  endfunction

  function automatic logic [15:0] imem_word(input logic [31:0] a);
    if (a < 32'd4) return imem[a[1:0]];
    return 16'hA5A5 ^ a[15:0];
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_ret_hi = 16'd0; m_vec_hi = 16'd0;
    m_flush = 1'b0; m_left = 2; m_base = 0;
  endtask

  task automatic model_step();
    logic        nf;
    logic [15:0] w;
    nf = 1'b0;
    if (m_left != 0) begin
      w = imem_word(m_addr());
      if (m_left == 2) m_vec_hi = w;
      else begin
        m_pc = {m_vec_hi, w};
        nf = 1'b1;
      end
      m_left = m_left - 1;
    end else begin
      if (pop_pc1) begin
        m_pc = {m_ret_hi, dmem_rdata}; nf = 1'b1;
      end else if (pc_sel == 2'b11) begin
        m_pc = branch_target; nf = 1'b1;
      end else if (pc_sel == 2'b10) begin
        m_left = 2; m_base = 2;
      end else if (pc_sel == 2'b01) begin
        m_left = 2; m_base = 0;
      end else if (fetch_pc_enable) begin
        m_pc = m_pc + 32'd1;
      end
      if (pop_pc2 && !pop_pc1) m_ret_hi = dmem_rdata;
    end
    m_flush = nf;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle_inputs();
    fetch_pc_enable = 1'b0; pc_sel = 2'b00; branch_target = 32'd0;
    pop_pc2 = 1'b0; pop_pc1 = 1'b0; dmem_rdata = 16'd0;
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        pop2;
    logic        pop1;
    logic [15:0] rdata;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_busy;
    logic [31:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [1:0] sel, input logic [31:0] tgt,
                              input logic pop2, input logic pop1, input logic [15:0] rdata,
                              input logic [31:0] epc, input logic efl, input logic ebusy,
                              input logic [31:0] eaddr);
    vec_t v;
    v.en = en; v.sel = sel; v.tgt = tgt; v.pop2 = pop2; v.pop1 = pop1; v.rdata = rdata;
    v.exp_pc = epc; v.exp_flush = efl; v.exp_busy = ebusy; v.exp_addr = eaddr;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    // Starts from RUN with pc=0x40 and return staging 0 (just after boot).
    tbl[0]  = mk(0, 2'b11, 32'hFFFF_FFFE, 0, 0, 16'h0000, 32'hFFFF_FFFE, 1, 0, 32'hFFFF_FFFE);
    tbl[1]  = mk(1, 2'b00, 32'h0,         0, 0, 16'h0000, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
    tbl[2]  = mk(1, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0000, 0, 0, 32'h0000_0000);
    tbl[3]  = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0000, 0, 0, 32'h0000_0000);
    tbl[4]  = mk(0, 2'b00, 32'h0,         1, 0, 16'h1234, 32'h0000_0000, 0, 0, 32'h0000_0000);
    tbl[5]  = mk(0, 2'b00, 32'h0,         0, 1, 16'h5678, 32'h1234_5678, 1, 0, 32'h1234_5678);
    tbl[6]  = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h1234_5678, 0, 0, 32'h1234_5678);
    tbl[7]  = mk(0, 2'b11, 32'h50,        0, 0, 16'h0000, 32'h0000_0050, 1, 0, 32'h0000_0050);
    tbl[8]  = mk(1, 2'b10, 32'h0,         0, 0, 16'h0000, 32'h0000_0050, 0, 1, 32'h0000_0002);
    tbl[9]  = mk(1, 2'b11, 32'hDEAD,      1, 1, 16'hBEEF, 32'h0000_0050, 0, 1, 32'h0000_0003);
    tbl[10] = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0200, 1, 0, 32'h0000_0200);
    tbl[11] = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0200, 0, 0, 32'h0000_0200);
    tbl[12] = mk(0, 2'b00, 32'h0,         1, 0, 16'h0000, 32'h0000_0200, 0, 0, 32'h0000_0200);
    tbl[13] = mk(0, 2'b11, 32'h99,        0, 1, 16'h0010, 32'h0000_0010, 1, 0, 32'h0000_0010);
    tbl[14] = mk(0, 2'b00, 32'h0,         1, 1, 16'h0020, 32'h0000_0020, 1, 0, 32'h0000_0020);
    tbl[15] = mk(0, 2'b00, 32'h0,         0, 1, 16'h0030, 32'h0000_0030, 1, 0, 32'h0000_0030);
    tbl[16] = mk(1, 2'b01, 32'h0,         0, 0, 16'h0000, 32'h0000_0030, 0, 1, 32'h0000_0000);
    tbl[17] = mk(1, 2'b00, 32'h0,         0, 1, 16'h7777, 32'h0000_0030, 0, 1, 32'h0000_0001);
    tbl[18] = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0040, 1, 0, 32'h0000_0040);
    tbl[19] = mk(0, 2'b00, 32'h0,         0, 0, 16'h0000, 32'h0000_0040, 0, 0, 32'h0000_0040);
  end

  // ---------------- test sequence ----------------
  initial begin
    imem[0] = 16'h0000; imem[1] = 16'h0040; imem[2] = 16'h0000; imem[3] = 16'h0200;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #12;
    chk("reset_pc",    pc,                 32'd0);
    chk("reset_flush", {31'd0, fetch_flush}, 32'd0);
    chk("reset_busy",  {31'd0, vec_busy},    32'd1);
    chk("reset_addr",  imem_addr,          32'd0);

    // Boot sequence
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("boot1_pc",   pc,                  32'd0);
    chk("boot1_addr", imem_addr,           32'd1);
    chk("boot1_busy", {31'd0, vec_busy},   32'd1);
    tick();
    chk("boot2_pc",    pc,                   32'h40);
    chk("boot2_flush", {31'd0, fetch_flush}, 32'd1);
    chk("boot2_busy",  {31'd0, vec_busy},    32'd0);
    tick();
    chk("boot3_flush", {31'd0, fetch_flush}, 32'd0);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      fetch_pc_enable = tbl[i].en;  pc_sel = tbl[i].sel; branch_target = tbl[i].tgt;
      pop_pc2 = tbl[i].pop2; pop_pc1 = tbl[i].pop1; dmem_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("tbl%0d_pc", i),    pc,                   tbl[i].exp_pc);
      chk($sformatf("tbl%0d_flush", i), {31'd0, fetch_flush}, {31'd0, tbl[i].exp_flush});
      chk($sformatf("tbl%0d_busy", i),  {31'd0, vec_busy},    {31'd0, tbl[i].exp_busy});
      chk($sformatf("tbl%0d_addr", i),  imem_addr,            tbl[i].exp_addr);
    end
    idle_inputs();

    // Reset in the middle of an interrupt vector load
    pc_sel = 2'b10;
    tick();
    pc_sel = 2'b00;
    tick();
    chk("midrst_intlo_addr", imem_addr, 32'd3);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_pc",    pc,                   32'd0);
    chk("midrst_addr",  imem_addr,            32'd0);
    chk("midrst_busy",  {31'd0, vec_busy},    32'd1);
    chk("midrst_flush", {31'd0, fetch_flush}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reboot1_addr", imem_addr, 32'd1);
    tick();
    chk("reboot2_pc",    pc,                   32'h40);
    chk("reboot2_flush", {31'd0, fetch_flush}, 32'd1);

    // Randomized run against the model
    for (int i = 0; i < 4; i++) imem[i] = 16'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fetch_pc_enable = 1'($urandom_range(0, 1));
      pc_sel          = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      branch_target   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      pop_pc2         = ($urandom_range(0, 5) == 0);
      pop_pc1         = ($urandom_range(0, 11) == 0);
      dmem_rdata      = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        chk($sformatf("rnd%0d_rst_pc", cyc), pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
      end
      tick();
      chk($sformatf("rnd%0d_pc", cyc),    pc,                   m_pc);
      chk($sformatf("rnd%0d_flush", cyc), {31'd0, fetch_flush}, {31'd0, m_flush});
      chk($sformatf("rnd%0d_busy", cyc),  {31'd0, vec_busy},    {31'd0, (m_left != 0)});
      chk($sformatf("rnd%0d_addr", cyc),  imem_addr,            m_addr());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
